parity_serial_rx: RTL and testbench

Serial receiver that checks XOR parity. It deframes a bit stream produced by the team's XOR-parity serial transmitter: start bit, DATA_W data bits sent LSB first, one parity bit, one stop bit. A running XOR of the data bits is compared against the received parity bit. The block presents the recovered word with parity and framing status. It sits behind the bit-timing block, which supplies one bit_en strobe per bit period.

---
 rtl/parity_serial_rx_pkg.sv | 17 +
 rtl/parity_accum.sv | 23 ++
 rtl/parity_serial_rx.sv | 125 ++++++++++++
 tb/tb_parity_serial_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_serial_rx_pkg.sv
// Shared definitions for the XOR-parity serial receiver and its transmitter peer.
package parity_serial_rx_pkg;

    // Frame position tracked by the receive FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // Line levels that delimit a frame.
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// 1-bit running XOR accumulator with synchronous clear and enable.
// Kept standalone so the transmitter can reuse it for parity generation.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;

    // Clear wins over enable; otherwise fold each enabled bit into the XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     acc_q <= 1'b0;
        else if (clr_i) acc_q <= 1'b0;
        else if (en_i)  acc_q <= acc_q ^ bit_i;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/parity_serial_rx.sv
// Deframes start / DATA_W data bits (LSB first) / parity / stop and reports
// the recovered word with parity and framing status. Advances only on bit_en.
module parity_serial_rx
    import parity_serial_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;
    logic              busy_q;
    logic              acc_clr, acc_en, acc;

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .bit_i (rx_bit),
        .acc_o (acc)
    );

    // Next-state and output decode; clr aborts the frame ahead of any strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        perr_d  = perr_q;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        dv_d    = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_clr = 1'b1;
        end else if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (rx_bit == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                    end
                end
                DATA: begin
                    // Right shift: the first (LSB) bit ends up at bit 0.
                    sr_d             = sr_q >> 1;
                    sr_d[DATA_W-1]   = rx_bit;
                    acc_en           = 1'b1;
                    cnt_d            = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = PARITY;
                end
                PARITY: begin
                    perr_d  = acc ^ rx_bit ^ ODD_PARITY;
                    state_d = STOP;
                end
                STOP: begin
                    // Word is delivered even on a bad stop bit; frame_err flags it.
                    data_d  = sr_q;
                    pe_d    = perr_q;
                    fe_d    = (rx_bit != STOP_BIT);
                    dv_d    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            perr_q  <= 1'b0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            perr_q  <= perr_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            dv_q    <= dv_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
// Bench for parity_serial_rx: an even-parity and an odd-parity instance share
// one serial stream; each completed frame is compared with a word-level model.
module tb_parity_serial_rx;

    logic       clk = 1'b0;
    logic       rst_n, clr, bit_en, rx_bit;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;

    int n_chk  = 0;
    int n_pass = 0;
    int sc     = 0;  // bit_en strobes sampled so far

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         sc;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    parity_serial_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bit_en(bit_en), .rx_bit(rx_bit),
        .data_out(dout0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0), .busy(busy0)
    );

    parity_serial_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bit_en(bit_en), .rx_bit(rx_bit),
        .data_out(dout1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Count sampled strobes, used for latency and frame-spacing expectations.
    always @(posedge clk) if (bit_en) sc <= sc + 1;

    // Record every data_valid cycle seen on either instance.
    always @(negedge clk) begin
        if (dv0) q0.push_back('{dout0, pe0, fe0, sc});
        if (dv1) q1.push_back('{dout1, pe1, fe1, sc});
    end

    // Reference: parity error is the XOR of all data bits, the parity bit and the sense.
    function automatic logic exp_pe(input logic [7:0] d, input logic p, input logic odd);
        return (^d) ^ p ^ odd;
    endfunction

    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin @(posedge clk); #1; end
        bit_en = 1'b1;
        rx_bit = b;
        @(posedge clk); #1;
        bit_en = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int maxgap, output int stop_sc);
        send_bit(1'b0, $urandom_range(maxgap, 0));
        for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(maxgap, 0));
        send_bit(p, $urandom_range(maxgap, 0));
        send_bit(s, $urandom_range(maxgap, 0));
        stop_sc = sc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; bit_en = 1'b0; rx_bit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({dout0, dv0, pe0, fe0, busy0} !== 12'h0)
            $display("FAIL reset_even: got %h exp 000", {dout0, dv0, pe0, fe0, busy0}); else n_pass++;
        n_chk++; if ({dout1, dv1, pe1, fe1, busy1} !== 12'h0)
            $display("FAIL reset_odd: got %h exp 000", {dout1, dv1, pe1, fe1, busy1}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] td[5] = '{8'hA5, 8'hA5, 8'h3C, 8'h00, 8'h01};
        logic       tp[5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
        logic       ts[5] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        int  ssc;
        ev_t e0, e1;
        for (int k = 0; k < 5; k++) begin
            send_frame(td[k], tp[k], ts[k], 3, ssc);
            @(negedge clk); #1;
            n_chk++;
            if (q0.size() != 1 || q1.size() != 1) begin
                $display("FAIL dir_pulses[%0d]: got %0d/%0d exp 1/1", k, q0.size(), q1.size());
                q0.delete(); q1.delete();
            end else begin
                n_pass++;
                e0 = q0.pop_front(); e1 = q1.pop_front();
                n_chk++; if (e0.d !== td[k]) $display("FAIL dir_data[%0d]: got %h exp %h", k, e0.d, td[k]); else n_pass++;
                n_chk++; if (e1.d !== td[k]) $display("FAIL dir_data_odd[%0d]: got %h exp %h", k, e1.d, td[k]); else n_pass++;
                n_chk++; if (e0.pe !== exp_pe(td[k], tp[k], 1'b0)) $display("FAIL dir_pe_even[%0d]: got %b exp %b", k, e0.pe, exp_pe(td[k], tp[k], 1'b0)); else n_pass++;
                n_chk++; if (e1.pe !== exp_pe(td[k], tp[k], 1'b1)) $display("FAIL dir_pe_odd[%0d]: got %b exp %b", k, e1.pe, exp_pe(td[k], tp[k], 1'b1)); else n_pass++;
                n_chk++; if (e0.fe !== ~ts[k]) $display("FAIL dir_fe[%0d]: got %b exp %b", k, e0.fe, ~ts[k]); else n_pass++;
                n_chk++; if (e0.sc != ssc) $display("FAIL dir_latency[%0d]: got strobe %0d exp %0d", k, e0.sc, ssc); else n_pass++;
            end
            // Outputs must hold after the pulse.
            repeat (3) @(posedge clk);
            #1;
            n_chk++; if (dout0 !== td[k] || dv0 !== 1'b0 || busy0 !== 1'b0)
                $display("FAIL dir_hold[%0d]: got %h/%b/%b exp %h/0/0", k, dout0, dv0, busy0, td[k]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[2] = '{8'h5A, 8'hFF};
        int  ssc;
        ev_t e0, e1;
        send_frame(d[0], ^d[0], 1'b1, 3, ssc);
        send_frame(d[1], ^d[1], 1'b1, 3, ssc);
        @(negedge clk); #1;
        n_chk++;
        if (q0.size() != 2 || q1.size() != 2) begin
            $display("FAIL b2b_pulses: got %0d/%0d exp 2/2", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end else begin
            n_pass++;
            e0 = q0.pop_front(); e1 = q0.pop_front();
            n_chk++; if (e0.d !== d[0] || e0.pe !== 1'b0 || e0.fe !== 1'b0)
                $display("FAIL b2b_first: got %h/%b/%b exp 5a/0/0", e0.d, e0.pe, e0.fe); else n_pass++;
            n_chk++; if (e1.d !== d[1] || e1.pe !== 1'b0 || e1.fe !== 1'b0)
                $display("FAIL b2b_second: got %h/%b/%b exp ff/0/0", e1.d, e1.pe, e1.fe); else n_pass++;
            n_chk++; if (e1.sc - e0.sc != 11) $display("FAIL b2b_spacing: got %0d exp 11", e1.sc - e0.sc); else n_pass++;
            n_chk++; if (e1.sc != ssc) $display("FAIL b2b_latency: got %0d exp %0d", e1.sc, ssc); else n_pass++;
            e0 = q1.pop_front(); e1 = q1.pop_front();
            n_chk++; if (e0.pe !== 1'b1 || e1.pe !== 1'b1)
                $display("FAIL b2b_odd_pe: got %b%b exp 11", e0.pe, e1.pe); else n_pass++;
        end
    endtask

    task automatic test_clr();
        int  ssc;
        ev_t e0;
        logic [7:0] prev;
        prev = dout0;
        send_bit(1'b0, 0);
        #1;
        n_chk++; if (busy0 !== 1'b1) $display("FAIL clr_busy_start: got %b exp 1", busy0); else n_pass++;
        send_bit(1'b1, 1); send_bit(1'b0, 0); send_bit(1'b1, 2); send_bit(1'b0, 0);
        clr = 1'b1;
        send_bit(1'b0, 0);
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL clr_busy: got %b%b exp 00", busy0, busy1); else n_pass++;
        n_chk++; if (dout0 !== prev) $display("FAIL clr_keep_data: got %h exp %h", dout0, prev); else n_pass++;
        send_frame(8'h81, 1'b0, 1'b1, 2, ssc);
        @(negedge clk); #1;
        n_chk++;
        if (q0.size() != 1 || q1.size() != 1) begin
            $display("FAIL clr_pulses: got %0d/%0d exp 1/1", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end else begin
            n_pass++;
            e0 = q0.pop_front(); void'(q1.pop_front());
            n_chk++; if (e0.d !== 8'h81 || e0.pe !== 1'b0 || e0.fe !== 1'b0)
                $display("FAIL clr_frame: got %h/%b/%b exp 81/0/0", e0.d, e0.pe, e0.fe); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int  ssc;
        ev_t e0;
        send_frame(8'h7E, 1'b0, 1'b0, 1, ssc);  // leave data/frame_err nonzero
        @(negedge clk); #1;
        q0.delete(); q1.delete();
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 1);
        rst_n = 1'b0;
        #1;
        n_chk++; if ({dout0, dv0, pe0, fe0, busy0, dout1, dv1, pe1, fe1, busy1} !== 24'h0)
            $display("FAIL rst_mid_async: got %h exp 000000", {dout0, dv0, pe0, fe0, busy0, dout1, dv1, pe1, fe1, busy1}); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, 2, ssc);
        @(negedge clk); #1;
        n_chk++;
        if (q0.size() != 1 || q1.size() != 1) begin
            $display("FAIL rst_pulses: got %0d/%0d exp 1/1", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end else begin
            n_pass++;
            e0 = q0.pop_front(); void'(q1.pop_front());
            n_chk++; if (e0.d !== 8'h81 || e0.pe !== 1'b0 || e0.fe !== 1'b0)
                $display("FAIL rst_frame: got %h/%b/%b exp 81/0/0", e0.d, e0.pe, e0.fe); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        int         ssc;
        ev_t        e0, e1;
        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            p = ($urandom_range(3, 0) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(4, 0) != 0);
            repeat ($urandom_range(2, 0)) send_bit(1'b1, $urandom_range(3, 0));
            send_frame(d, p, s, 3, ssc);
            @(negedge clk); #1;
            n_chk++;
            if (q0.size() != 1 || q1.size() != 1) begin
                $display("FAIL rnd_pulses[%0d]: got %0d/%0d exp 1/1", k, q0.size(), q1.size());
                q0.delete(); q1.delete();
            end else begin
                n_pass++;
                e0 = q0.pop_front(); e1 = q1.pop_front();
                n_chk++; if (e0.d !== d || e1.d !== d) $display("FAIL rnd_data[%0d]: got %h/%h exp %h", k, e0.d, e1.d, d); else n_pass++;
                n_chk++; if (e0.pe !== exp_pe(d, p, 1'b0) || e1.pe !== exp_pe(d, p, 1'b1))
                    $display("FAIL rnd_pe[%0d]: got %b%b exp %b%b", k, e0.pe, e1.pe, exp_pe(d, p, 1'b0), exp_pe(d, p, 1'b1)); else n_pass++;
                n_chk++; if (e0.fe !== ~s || e1.fe !== ~s) $display("FAIL rnd_fe[%0d]: got %b%b exp %b", k, e0.fe, e1.fe, ~s); else n_pass++;
                n_chk++; if (e0.sc != ssc) $display("FAIL rnd_latency[%0d]: got %0d exp %0d", k, e0.sc, ssc); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_clr();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
